// File: rtl/rc5_key_sched_if.sv
// Bus between the RC5-32/12/16 key-expansion engine and its user.
// Key load is a one-cycle strobe; the table is qualified by keyex_vld.
interface rc5_key_sched_if;
  logic [127:0] key;
  logic         key_en;
  logic [831:0] keyex;
  logic         keyex_vld;
  logic         busy;
  logic         done;
  logic [1:0]   state;

  modport master (
    output key, key_en,
    input  keyex, keyex_vld, busy, done, state
  );

  modport slave (
    input  key, key_en,
    output keyex, keyex_vld, busy, done, state
  );
endinterface

// File: rtl/rc5_key_sched.sv
// RC5-32/12/16 key expansion: 78 mixing steps, one per clock, producing the
// 26-word S table as a packed bus with S[0] in the top word.
module rc5_key_sched #(
  parameter logic [31:0] P32 = 32'hB7E15163,
  parameter logic [31:0] Q32 = 32'h9E3779B9
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  rc5_key_sched_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MIX  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [6:0] LAST_STEP = 7'd77;
  localparam logic [4:0] LAST_IDX  = 5'd25;

  logic [31:0] s_q [26];
  logic [31:0] l_q [4];
  logic [31:0] a_q, b_q;
  logic [4:0]  i_q;
  logic [1:0]  j_q;
  logic [6:0]  step_q;
  logic [1:0]  state_q;
  logic        done_q;
  logic        vld_q;

  logic [31:0] l_init [4];
  logic [31:0] a_sum, a_new, b_sum, ab_sum, b_new;
  logic [63:0] b_rot;

  function automatic logic [31:0] s_init(input int n);
    return P32 + Q32 * 32'(n);
  endfunction

  // Little-endian word packing: byte k sits at key[127-8k -: 8].
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      l_init[j] = {bus.key[127-8*(4*j+3) -: 8], bus.key[127-8*(4*j+2) -: 8],
                   bus.key[127-8*(4*j+1) -: 8], bus.key[127-8*(4*j)   -: 8]};
    end
  end

  always_comb begin
    a_sum  = s_q[i_q] + a_q + b_q;
    a_new  = {a_sum[28:0], a_sum[31:29]};
    b_sum  = l_q[j_q] + a_new + b_q;
    ab_sum = a_new + b_q;
    // Doubling the word makes a left rotate a plain shift; amount 0 is identity.
    b_rot  = {b_sum, b_sum} << ab_sum[4:0];
    b_new  = b_rot[63:32];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 26; k++) s_q[k] <= '0;
      for (int k = 0; k < 4; k++)  l_q[k] <= '0;
      a_q     <= '0;
      b_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      step_q  <= '0;
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      done_q <= (state_q == ST_DONE);
      if (bus.key_en) begin
        for (int k = 0; k < 26; k++) s_q[k] <= s_init(k);
        for (int k = 0; k < 4; k++)  l_q[k] <= l_init[k];
        a_q     <= '0;
        b_q     <= '0;
        i_q     <= '0;
        j_q     <= '0;
        step_q  <= '0;
        vld_q   <= 1'b0;
        state_q <= ST_MIX;
      end else begin
        case (state_q)
          ST_MIX: begin
            s_q[i_q] <= a_new;
            l_q[j_q] <= b_new;
            a_q      <= a_new;
            b_q      <= b_new;
            i_q      <= (i_q == LAST_IDX) ? 5'd0 : i_q + 5'd1;
            j_q      <= j_q + 2'd1;
            step_q   <= step_q + 7'd1;
            if (step_q == LAST_STEP) state_q <= ST_DONE;
          end
          ST_DONE: begin
            vld_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    bus.keyex = '0;
    for (int k = 0; k < 26; k++) bus.keyex[32*(26-k)-1 -: 32] = s_q[k];
  end

  assign bus.keyex_vld = vld_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.state     = state_q;

endmodule

// File: tb/tb_rc5_key_sched.sv
// Bench for rc5_key_sched: golden key-schedule model feeding an expected-table
// queue, plus an RC5 encryption of the zero-key table against the known vector.
module tb_rc5_key_sched;

  logic clk = 1'b0;
  logic rst_n;
  rc5_key_sched_if bus();

  rc5_key_sched dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [831:0] exp_q[$];

  task automatic check(input string tag, input logic [831:0] got, input logic [831:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rol(input logic [31:0] x, input logic [4:0] n);
    if (n == 5'd0) return x;
    return (x << n) | (x >> (32 - int'(n)));
  endfunction

  function automatic logic [831:0] model(input logic [127:0] key);
    logic [31:0] s [26];
    logic [31:0] l [4];
    logic [7:0]  kb;
    logic [31:0] a, b;
    int ii, jj;
    logic [831:0] r;
    for (int j = 0; j < 4; j++) l[j] = '0;
    for (int k = 15; k >= 0; k--) begin
      kb = key[127-8*k -: 8];
      l[k/4] = (l[k/4] << 8) + {24'd0, kb};
    end
    s[0] = 32'hB7E15163;
    for (int k = 1; k < 26; k++) s[k] = s[k-1] + 32'h9E3779B9;
    a = '0; b = '0; ii = 0; jj = 0;
    for (int t = 0; t < 78; t++) begin
      a = rol(s[ii] + a + b, 5'd3);
      s[ii] = a;
      b = a + b;
      b = rol(l[jj] + b, b[4:0]);
      l[jj] = b;
      ii = (ii + 1) % 26;
      jj = (jj + 1) % 4;
    end
    r = '0;
    for (int k = 0; k < 26; k++) r[32*(26-k)-1 -: 32] = s[k];
    return r;
  endfunction

  function automatic logic [63:0] rc5_enc(input logic [831:0] tbl);
    logic [31:0] a, b;
    a = tbl[831 -: 32];
    b = tbl[799 -: 32];
    for (int r = 1; r <= 12; r++) begin
      a = rol(a ^ b, b[4:0]) + tbl[32*(26-2*r)-1 -: 32];
      b = rol(b ^ a, a[4:0]) + tbl[32*(25-2*r)-1 -: 32];
    end
    return {a, b};
  endfunction

  // Call positioned just after a falling edge; returns one falling edge after the load edge.
  task automatic load_key(input logic [127:0] k);
    bus.key    = k;
    bus.key_en = 1'b1;
    exp_q.push_back(model(k));
    @(negedge clk);
    bus.key_en = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int seen;
    int at;
    bit early_vld;
    logic [831:0] e;
    seen = 0; at = -1; early_vld = 1'b0;
    for (int n = 1; n <= 90; n++) begin
      @(negedge clk);
      if (n == 78) check({tag, "_busy78"}, 832'(bus.busy), 832'(1));
      if (bus.done) begin
        seen++;
        if (at < 0) at = n;
        if (bus.keyex_vld) begin
          if (exp_q.size() == 0) check({tag, "_sb_empty"}, 832'(0), 832'(1));
          else begin
            e = exp_q.pop_front();
            check({tag, "_table"}, bus.keyex, e);
          end
        end
      end else if (bus.keyex_vld && at < 0) early_vld = 1'b1;
    end
    check({tag, "_done_cnt"}, 832'(seen), 832'(1));
    check({tag, "_done_lat"}, 832'(at), 832'(79));
    check({tag, "_early_vld"}, 832'(early_vld), 832'(0));
    check({tag, "_vld_end"}, 832'(bus.keyex_vld), 832'(1));
    check({tag, "_busy_end"}, 832'(bus.busy), 832'(0));
  endtask

  logic [127:0] k_tmp;
  logic [831:0] drop;

  initial begin
    bus.key    = '0;
    bus.key_en = 1'b0;
    rst_n      = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_keyex", bus.keyex, 832'(0));
    check("rst_vld", 832'(bus.keyex_vld), 832'(0));
    check("rst_busy", 832'(bus.busy), 832'(0));
    check("rst_done", 832'(bus.done), 832'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    load_key(128'h0);
    check("zero_busy0", 832'(bus.busy), 832'(1));
    wait_done("zero");
    check("zero_ct", 832'(rc5_enc(bus.keyex)), 832'(64'hEEDBA521_6D8F4B15));

    load_key(128'h000102030405060708090A0B0C0D0E0F);
    check("inc_vld_drop", 832'(bus.keyex_vld), 832'(0));
    wait_done("inc");
    k_tmp = 128'h000102030405060708090A0B0C0D0E0F;
    drop  = model(k_tmp);
    check("inc_s0", 832'(bus.keyex[831:800]), 832'(drop[831:800]));

    for (int t = 0; t < 2; t++) begin
      load_key({$urandom, $urandom, $urandom, $urandom});
      wait_done("rand");
    end

    load_key({$urandom, $urandom, $urandom, $urandom});
    repeat (40) @(negedge clk);
    drop = exp_q.pop_back();
    load_key({$urandom, $urandom, $urandom, $urandom});
    wait_done("abort");

    load_key({$urandom, $urandom, $urandom, $urandom});
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_keyex", bus.keyex, 832'(0));
    check("mrst_vld", 832'(bus.keyex_vld), 832'(0));
    check("mrst_busy", 832'(bus.busy), 832'(0));
    check("mrst_done", 832'(bus.done), 832'(0));
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mrst_vld_after", 832'(bus.keyex_vld), 832'(0));
    load_key({$urandom, $urandom, $urandom, $urandom});
    wait_done("mrst");

    load_key({$urandom, $urandom, $urandom, $urandom});
    repeat (78) @(negedge clk);
    check("b2b_done_pre", 832'(bus.done), 832'(0));
    check("b2b_busy_pre", 832'(bus.busy), 832'(1));
    drop = exp_q.pop_back();
    load_key({$urandom, $urandom, $urandom, $urandom});
    check("b2b_done_pulse", 832'(bus.done), 832'(1));
    check("b2b_vld_low", 832'(bus.keyex_vld), 832'(0));
    wait_done("b2b");

    check("sb_drained", 832'(exp_q.size()), 832'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
